fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the ARM pipeline, directly upstream of Instruction_Memory.
//   Owns the PC register and drives the memory address. Registers the
//   returned word into the IF/ID pipeline register with a valid bit.
//   Handles hazard freeze, branch redirect/flush, and halting at end of program.
// PARAMETERS
//   PC_RESET   32'd0   PC value loaded on reset
//   PC_STEP    32'd4   byte increment per sequential fetch
//   IMEM_BYTES 32'd28  program size in bytes; fetch halts when PC >= IMEM_BYTES
// PORTS
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous, active-high reset
//   freeze          in   1   hazard stall: hold PC and IF/ID contents
//   branch_taken    in   1   redirect request from EXE
//   branch_address  in   32  byte address of branch target
//   imem_pc         out  32  address to instruction memory (= PC register)
//   imem_instruction in  32  word returned by memory, same cycle (combinational)
//   id_pc           out  32  registered PC+PC_STEP of the issued instruction
//   id_instruction  out  32  registered instruction to decode
//   id_valid        out  1   id_instruction is a real instruction, not a bubble
//   halted          out  1   fetch stopped at end of program
//   fetch_count     out  16  instructions issued since reset, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset, sync, highest priority:
//     - pc = PC_RESET; id_pc = 0; id_instruction = 0; id_valid = 0
//     - halted = 0; fetch_count = 0; state = FETCH
//   imem_pc = pc, combinational from the register. Memory word is sampled in the same cycle.
//   States: FETCH, HALT. halted = (state == HALT).
//   Per-cycle priority: rst > branch_taken > freeze > state action.
//   branch_taken (either state, overrides freeze):
//     - pc <= {branch_address[31:2], 2'b00}; low bits are forced to 0
//     - IF/ID flushed: id_valid <= 0, id_instruction <= 0, id_pc <= 0
//     - state <= FETCH if the aligned target < IMEM_BYTES, else HALT
//     - fetch_count unchanged
//   freeze (no branch):
//     - pc, id_*, state and fetch_count all hold
//     - the memory word is not sampled
//   FETCH, no branch, no freeze:
//     - id_instruction <= imem_instruction; id_pc <= pc + PC_STEP; id_valid <= 1
//     - pc <= pc + PC_STEP; fetch_count <= fetch_count + 1 (saturating)
//     - if pc + PC_STEP >= IMEM_BYTES, state <= HALT
//     - the last instruction is still issued in that cycle
//   HALT, no branch, no freeze:
//     - pc holds; id_valid <= 0; id_instruction <= 0; id_pc <= 0
//   Arithmetic: 32-bit unsigned; pc + PC_STEP wraps mod 2^32 with no special handling.
//     The comparison against IMEM_BYTES is unsigned.
//   Latency: the word at address A appears on id_instruction one cycle after imem_pc = A.
//     It stays on id_instruction while freeze is held.
//   Reset while frozen or mid-branch: reset wins; all state takes reset values next cycle.
// TESTING
//   1. Reset, then 7 free cycles:
//      - imem_pc steps 0,4,...,24
//      - id_pc 4..28, id_valid=1 each cycle
//      - halted=1 after the issue at pc=24; fetch_count=7
//   2. freeze=1 for 3 cycles at pc=8:
//      - pc stays 8; id_instruction/id_pc hold word@4 and 8
//      - fetch_count holds; resumes at 8 with no lost or duplicated word
//   3. branch_taken=1, branch_address=32'd13, together with freeze=1:
//      - next cycle pc=12, id_valid=0, id_instruction=0
//      - the cycle after that issues word@12 with id_pc=16
//   4. In HALT, branch_taken with branch_address=0:
//      - halted=0 next cycle; refetch from 0
//      - branch_address=32 instead: stays halted with pc=32
//   5. rst asserted while frozen at pc=16:
//      - next cycle pc=0, id_valid=0, fetch_count=0, halted=0
//   6. IMEM_BYTES=4 with fetch_count preset near limit via a long run:
//      - a single issue then HALT
//      - fetch_count saturation is checked with the PC_STEP=0 override, reaching 16'hFFFF and holding

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and registers
// the fetched word into IF/ID, with freeze, branch redirect/flush and end-of-program halt.
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'd0,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter logic [31:0] IMEM_BYTES = 32'd28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic        id_valid_reg, id_valid_next;
  logic [15:0] count_reg, count_next;

  logic [31:0] pc_inc;
  logic [31:0] branch_target;

  assign pc_inc        = pc_reg + PC_STEP;
  assign branch_target = {branch_address[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      pc_reg       <= PC_RESET;
      id_pc_reg    <= 32'd0;
      id_instr_reg <= 32'd0;
      id_valid_reg <= 1'b0;
      count_reg    <= 16'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      id_pc_reg    <= id_pc_next;
      id_instr_reg <= id_instr_next;
      id_valid_reg <= id_valid_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    id_pc_next    = id_pc_reg;
    id_instr_next = id_instr_reg;
    id_valid_next = id_valid_reg;
    count_next    = count_reg;

    // A redirect overrides freeze: the target is fetched even while decode is stalled.
    if (branch_taken) begin
      pc_next       = branch_target;
      id_pc_next    = 32'd0;
      id_instr_next = 32'd0;
      id_valid_next = 1'b0;
      state_next    = (branch_target < IMEM_BYTES) ? FETCH : HALT;
    end else if (!freeze) begin
      unique case (state_reg)
        FETCH: begin
          id_instr_next = imem_instruction;
          id_pc_next    = pc_inc;
          id_valid_next = 1'b1;
          pc_next       = pc_inc;
          count_next    = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
          if (pc_inc >= IMEM_BYTES) state_next = HALT;
        end
        HALT: begin
          id_instr_next = 32'd0;
          id_pc_next    = 32'd0;
          id_valid_next = 1'b0;
        end
      endcase
    end
  end

  assign imem_pc        = pc_reg;
  assign id_pc          = id_pc_reg;
  assign id_instruction = id_instr_reg;
  assign id_valid       = id_valid_reg;
  assign halted         = (state_reg == HALT);
  assign fetch_count    = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a program-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] IMEM = 32'd28;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_address;
  logic [31:0] imem_pc, imem_instruction, id_pc, id_instruction;
  logic        id_valid, halted;
  logic [15:0] fetch_count;

  logic        rst_aux;
  logic [31:0] s_pc, s_ins, s_id_pc, s_id_ins;
  logic        s_valid, s_halted;
  logic [15:0] s_count;
  logic [31:0] t_pc, t_ins, t_id_pc, t_id_ins;
  logic        t_valid, t_halted;
  logic [15:0] t_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory contents: an arbitrary scramble of the byte address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  assign imem_instruction = word_at(imem_pc);
  assign s_ins            = word_at(s_pc);
  assign t_ins            = word_at(t_pc);

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_pc(imem_pc),
    .imem_instruction(imem_instruction), .id_pc(id_pc),
    .id_instruction(id_instruction), .id_valid(id_valid), .halted(halted),
    .fetch_count(fetch_count));

  fetch_stage #(.IMEM_BYTES(32'd4)) u_small (
    .clk(clk), .rst(rst_aux), .freeze(1'b0), .branch_taken(1'b0),
    .branch_address(32'd0), .imem_pc(s_pc), .imem_instruction(s_ins),
    .id_pc(s_id_pc), .id_instruction(s_id_ins), .id_valid(s_valid),
    .halted(s_halted), .fetch_count(s_count));

  fetch_stage #(.PC_STEP(32'd0)) u_sat (
    .clk(clk), .rst(rst_aux), .freeze(1'b0), .branch_taken(1'b0),
    .branch_address(32'd0), .imem_pc(t_pc), .imem_instruction(t_ins),
    .id_pc(t_id_pc), .id_instruction(t_id_ins), .id_valid(t_valid),
    .halted(t_halted), .fetch_count(t_count));

  // Reference model: program counter walk over a 28-byte program.
  logic [31:0] m_pc, m_id_pc, m_id_ins;
  logic        m_valid, m_halted;
  int          m_issued;

  task automatic model_step();
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 0; m_id_pc = 0; m_id_ins = 0; m_valid = 0; m_halted = 0; m_issued = 0;
    end else if (branch_taken) begin
      tgt = branch_address & ~32'd3;
      m_pc = tgt; m_id_pc = 0; m_id_ins = 0; m_valid = 0;
      m_halted = (tgt >= IMEM);
    end else if (freeze) begin
      // everything holds
    end else if (!m_halted) begin
      m_id_ins = word_at(m_pc);
      m_pc     = m_pc + 4;
      m_id_pc  = m_pc;
      m_valid  = 1;
      m_issued = m_issued + 1;
      if (m_pc >= IMEM) m_halted = 1;
    end else begin
      m_id_pc = 0; m_id_ins = 0; m_valid = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [15:0] cnt;
    cnt = (m_issued > 65535) ? 16'hFFFF : 16'(m_issued);
    check("imem_pc", imem_pc, m_pc);
    check("id_pc", id_pc, m_id_pc);
    check("id_instruction", id_instruction, m_id_ins);
    check("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("fetch_count", {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  task automatic cycle(input logic r, input logic b, input logic [31:0] ba, input logic f);
    rst = r; branch_taken = b; branch_address = ba; freeze = f;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic run_to_halt();
    int k;
    k = 0;
    while (!halted && k < 20) begin
      cycle(0, 0, 0, 0);
      k++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    rst = 1; freeze = 0; branch_taken = 0; branch_address = 0; rst_aux = 1;
    m_pc = 0; m_id_pc = 0; m_id_ins = 0; m_valid = 0; m_halted = 0; m_issued = 0;

    // 1: reset then seven sequential issues
    cycle(1, 0, 0, 0);
    check("rst_pc", imem_pc, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0);
      check("seq_id_pc", id_pc, 32'(4 * i));
      check("seq_valid", {31'd0, id_valid}, 32'd1);
    end
    check("seq_halted", {31'd0, halted}, 32'd1);
    check("seq_count", {16'd0, fetch_count}, 32'd7);
    check("seq_last_word", id_instruction, word_at(32'd24));

    // 2: freeze for three cycles at pc=8
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1);
      check("frz_pc", imem_pc, 32'd8);
      check("frz_id_pc", id_pc, 32'd8);
      check("frz_word", id_instruction, word_at(32'd4));
      check("frz_count", {16'd0, fetch_count}, 32'd2);
    end
    cycle(0, 0, 0, 0);
    check("resume_word", id_instruction, word_at(32'd8));
    check("resume_id_pc", id_pc, 32'd12);
    check("resume_count", {16'd0, fetch_count}, 32'd3);

    // 3: branch to unaligned 13 while frozen
    cycle(0, 1, 32'd13, 1);
    check("br_pc", imem_pc, 32'd12);
    check("br_valid", {31'd0, id_valid}, 32'd0);
    check("br_ins", id_instruction, 32'd0);
    cycle(0, 0, 0, 0);
    check("br_word", id_instruction, word_at(32'd12));
    check("br_id_pc", id_pc, 32'd16);

    // 4: redirect out of HALT, then a redirect past the program end
    run_to_halt();
    cycle(0, 1, 32'd0, 0);
    check("unhalt", {31'd0, halted}, 32'd0);
    check("unhalt_pc", imem_pc, 32'd0);
    cycle(0, 0, 0, 0);
    check("refetch_word", id_instruction, word_at(32'd0));
    run_to_halt();
    cycle(0, 1, 32'd32, 0);
    check("far_halted", {31'd0, halted}, 32'd1);
    check("far_pc", imem_pc, 32'd32);
    cycle(0, 0, 0, 0);
    check("far_hold_pc", imem_pc, 32'd32);
    check("far_valid", {31'd0, id_valid}, 32'd0);

    // 5: reset while frozen at pc=16
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("pre_rst_pc", imem_pc, 32'd16);
    cycle(1, 0, 0, 1);
    check("rf_pc", imem_pc, 32'd0);
    check("rf_valid", {31'd0, id_valid}, 32'd0);
    check("rf_count", {16'd0, fetch_count}, 32'd0);
    check("rf_halted", {31'd0, halted}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, b, f;
      logic [31:0] ba;
      r  = ($urandom_range(99) < 2);
      b  = ($urandom_range(99) < 10);
      f  = ($urandom_range(99) < 25);
      ba = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(40));
      cycle(r, b, ba, f);
    end

    // 6: tiny program and counter saturation
    rst = 0; freeze = 0; branch_taken = 0;
    rst_aux = 1;
    @(posedge clk); #1;
    check("small_rst_pc", s_pc, 32'd0);
    rst_aux = 0;
    @(posedge clk); #1;
    check("small_valid", {31'd0, s_valid}, 32'd1);
    check("small_halted", {31'd0, s_halted}, 32'd1);
    check("small_count", {16'd0, s_count}, 32'd1);
    check("small_word", s_id_ins, word_at(32'd0));
    check("small_pc", s_pc, 32'd4);
    @(posedge clk); #1;
    check("small_bubble", {31'd0, s_valid}, 32'd0);
    check("small_count2", {16'd0, s_count}, 32'd1);
    repeat (65532) @(posedge clk);
    #1;
    check("sat_fffe", {16'd0, t_count}, 32'h0000FFFE);
    @(posedge clk); #1;
    check("sat_ffff", {16'd0, t_count}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", {16'd0, t_count}, 32'h0000FFFF);
    check("sat_pc", t_pc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
